// File: rtl/sparc_window_regfile.sv
// SPARC-style windowed register file: 8 globals plus NWIN overlapping windows, CWP/WIM, SAVE/RESTORE traps.
// Optional same-cycle write-to-read forwarding is enabled by defining REGWIN_BYPASS_EN.
module sparc_window_regfile #(
  parameter int DATA_W = 32,
  parameter int NWIN   = 8,
  parameter int CWP_W  = 3
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [4:0]        RA,
  input  logic [4:0]        RB,
  output logic [DATA_W-1:0] Aout,
  output logic [DATA_W-1:0] Bout,
  input  logic [4:0]        RW,
  input  logic [DATA_W-1:0] Win,
  input  logic              WE,
  input  logic              Save,
  input  logic              Restore,
  input  logic              WimWE,
  input  logic [NWIN-1:0]   WimIn,
  output logic [CWP_W-1:0]  Cwp,
  output logic [NWIN-1:0]   Wim,
  output logic              OvfTrap,
  output logic              UnfTrap
);

  localparam int DEPTH = 8 + 16 * NWIN;
  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [CWP_W-1:0]  r_cwp;
  logic [NWIN-1:0]   r_wim;
  logic              r_ovf;
  logic              r_unf;

  logic [CWP_W-1:0]  w_cwp_dec;
  logic [CWP_W-1:0]  w_cwp_inc;
  logic              w_save;
  logic              w_restore;
  logic              w_ovf;
  logic              w_unf;
  logic [IDX_W-1:0]  w_pa;
  logic [IDX_W-1:0]  w_pb;
  logic [IDX_W-1:0]  w_pw;
  logic [DATA_W-1:0] w_ra;
  logic [DATA_W-1:0] w_rb;

  // Physical layout: globals at 0..7, then per window 8 outs followed by 8 locals;
  // the ins of window w are the outs of the next window.
  function automatic logic [IDX_W-1:0] f_phys(input logic [4:0] a, input logic [CWP_W-1:0] w);
    int base;
    int nbase;
    base  = 8 + 16 * int'(w);
    nbase = (int'(w) == NWIN - 1) ? 8 : base + 16;
    case (a[4:3])
      2'd0:    f_phys = IDX_W'(a);
      2'd1:    f_phys = IDX_W'(base + int'(a[2:0]));
      2'd2:    f_phys = IDX_W'(base + 8 + int'(a[2:0]));
      default: f_phys = IDX_W'(nbase + int'(a[2:0]));
    endcase
  endfunction

  assign w_cwp_dec = (r_cwp == '0) ? CWP_W'(NWIN - 1) : r_cwp - 1'b1;
  assign w_cwp_inc = (r_cwp == CWP_W'(NWIN - 1)) ? '0 : r_cwp + 1'b1;
  assign w_save    = Save & ~Restore;
  assign w_restore = Restore & ~Save;
  assign w_ovf     = w_save & r_wim[w_cwp_dec];
  assign w_unf     = w_restore & r_wim[w_cwp_inc];

  assign w_pa = f_phys(RA, r_cwp);
  assign w_pb = f_phys(RB, r_cwp);
  assign w_pw = f_phys(RW, r_cwp);

  always_comb begin
    w_ra = (RA == 5'd0) ? '0 : r_mem[w_pa];
    w_rb = (RB == 5'd0) ? '0 : r_mem[w_pb];
`ifdef REGWIN_BYPASS_EN
    // Physical-index compare catches in/out alias hits as well as direct hits.
    if (WE && (RW != 5'd0) && (w_pw == w_pa)) w_ra = Win;
    if (WE && (RW != 5'd0) && (w_pw == w_pb)) w_rb = Win;
`endif
  end

  // Register contents are left untouched by reset; only window control is cleared.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_cwp <= '0;
      r_wim <= NWIN'(2);
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (WE && (RW != 5'd0)) r_mem[w_pw] <= Win;
      r_ovf <= w_ovf;
      r_unf <= w_unf;
      if (w_save && !w_ovf)
        r_cwp <= w_cwp_dec;
      else if (w_restore && !w_unf)
        r_cwp <= w_cwp_inc;
      if (WimWE) r_wim <= WimIn;
    end
  end

  assign Aout    = w_ra;
  assign Bout    = w_rb;
  assign Cwp     = r_cwp;
  assign Wim     = r_wim;
  assign OvfTrap = r_ovf;
  assign UnfTrap = r_unf;

endmodule

// File: tb/tb_sparc_window_regfile.sv
// Bench for sparc_window_regfile: directed scenarios plus randomized traffic against a window-level model.
// Build with +define+REGWIN_BYPASS_EN to exercise the forwarding variant.
module tb_sparc_window_regfile;
  localparam int DATA_W = 32;
  localparam int NWIN   = 8;
  localparam int CWP_W  = 3;

  logic              Clk;
  logic              Rst_n;
  logic [4:0]        RA, RB, RW;
  logic [DATA_W-1:0] Aout, Bout, Win;
  logic              WE, Save, Restore, WimWE;
  logic [NWIN-1:0]   WimIn, Wim;
  logic [CWP_W-1:0]  Cwp;
  logic              OvfTrap, UnfTrap;

  int checks = 0;
  int errors = 0;

  sparc_window_regfile #(.DATA_W(DATA_W), .NWIN(NWIN), .CWP_W(CWP_W)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .RA(RA), .RB(RB), .Aout(Aout), .Bout(Bout),
    .RW(RW), .Win(Win), .WE(WE), .Save(Save), .Restore(Restore),
    .WimWE(WimWE), .WimIn(WimIn), .Cwp(Cwp), .Wim(Wim),
    .OvfTrap(OvfTrap), .UnfTrap(UnfTrap)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: architectural view with explicit per-window outs/locals.
  logic [DATA_W-1:0] m_g   [8];
  bit                m_gv  [8];
  logic [DATA_W-1:0] m_out [NWIN][8];
  bit                m_outv[NWIN][8];
  logic [DATA_W-1:0] m_loc [NWIN][8];
  bit                m_locv[NWIN][8];
  int                m_cwp;
  logic [NWIN-1:0]   m_wim;
  bit                m_ovf, m_unf;

  function automatic void m_write(input int a, input int w, input logic [DATA_W-1:0] d);
    if (a == 0) return;
    if (a < 8) begin m_g[a] = d; m_gv[a] = 1'b1; end
    else if (a < 16) begin m_out[w][a-8] = d; m_outv[w][a-8] = 1'b1; end
    else if (a < 24) begin m_loc[w][a-16] = d; m_locv[w][a-16] = 1'b1; end
    else begin m_out[(w+1)%NWIN][a-24] = d; m_outv[(w+1)%NWIN][a-24] = 1'b1; end
  endfunction

  function automatic bit m_read(input int a, input int w, output logic [DATA_W-1:0] d);
    d = '0;
    if (a == 0) return 1'b1;
    if (a < 8) begin d = m_g[a]; return m_gv[a]; end
    if (a < 16) begin d = m_out[w][a-8]; return m_outv[w][a-8]; end
    if (a < 24) begin d = m_loc[w][a-16]; return m_locv[w][a-16]; end
    d = m_out[(w+1)%NWIN][a-24];
    return m_outv[(w+1)%NWIN][a-24];
  endfunction

  function automatic void m_edge();
    int n;
    if (WE) m_write(int'(RW), m_cwp, Win);
    m_ovf = 1'b0;
    m_unf = 1'b0;
    if (Save && !Restore) begin
      n = (m_cwp + NWIN - 1) % NWIN;
      if (m_wim[n]) m_ovf = 1'b1; else m_cwp = n;
    end else if (Restore && !Save) begin
      n = (m_cwp + 1) % NWIN;
      if (m_wim[n]) m_unf = 1'b1; else m_cwp = n;
    end
    if (WimWE) m_wim = WimIn;
  endfunction

  task automatic idle();
    RA = 0; RB = 0; RW = 0; Win = '0; WE = 0;
    Save = 0; Restore = 0; WimWE = 0; WimIn = '0;
  endtask

  task automatic tick();
    m_edge();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Rst_n = 1'b0;
    m_cwp = 0; m_wim = NWIN'(2); m_ovf = 0; m_unf = 0;
    repeat (2) @(negedge Clk);
    idle();
    Rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    #2 Rst_n = 1'b0;
    #1;
    checks++;
    if ({Cwp, Wim, OvfTrap, UnfTrap} !== {3'd0, 8'h02, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_state: got %h expected %h", {Cwp, Wim, OvfTrap, UnfTrap}, {3'd0, 8'h02, 2'b00});
    end
    do_reset();
    @(posedge Clk); #1;
    checks++;
    if ({Cwp, Wim, OvfTrap, UnfTrap} !== {3'd0, 8'h02, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_release: got %h expected %h", {Cwp, Wim, OvfTrap, UnfTrap}, {3'd0, 8'h02, 2'b00});
    end
  endtask

  task automatic test_alias();
    idle(); WE = 1; RW = 9; Win = 32'hA5A5A5A5; tick();
    idle(); Save = 1; tick();
    idle(); RA = 25; #1;
    checks++;
    if (Cwp !== 3'd7) begin errors++; $display("FAIL alias_cwp: got %0d expected 7", Cwp); end
    checks++;
    if (Aout !== 32'hA5A5A5A5) begin errors++; $display("FAIL alias_read: got %h expected a5a5a5a5", Aout); end
  endtask

  task automatic test_globals();
    idle(); WE = 1; RW = 0; Win = 32'hFFFFFFFF; tick();
    idle(); RA = 0; RB = 0; #1;
    checks++;
    if ({Aout, Bout} !== 64'h0) begin errors++; $display("FAIL r0_read: got %h/%h expected 0", Aout, Bout); end
    WE = 1; RW = 3; Win = 32'h12345678; tick();
    idle(); Save = 1; tick(); tick();
    idle(); RB = 3; #1;
    checks++;
    if ({Cwp, Bout} !== {3'd5, 32'h12345678}) begin
      errors++; $display("FAIL global_read: got cwp=%0d data=%h expected cwp=5 data=12345678", Cwp, Bout);
    end
  endtask

  task automatic test_reset_hold();
    idle(); WE = 1; RW = 5; Win = 32'h55; tick();
    RW = 5; Win = 32'hBAD; WE = 1;
    do_reset();
    RA = 5; #1;
    checks++;
    if ({Cwp, Aout} !== {3'd0, 32'h55}) begin
      errors++; $display("FAIL reset_write_ignored: got cwp=%0d r5=%h expected cwp=0 r5=00000055", Cwp, Aout);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    Restore = 1; tick(); idle();
    checks++;
    if ({Cwp, OvfTrap, UnfTrap} !== {3'd0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL unf_pulse: got %b expected 00001", {Cwp, OvfTrap, UnfTrap});
    end
    tick();
    checks++;
    if (UnfTrap !== 1'b0) begin errors++; $display("FAIL unf_clear: got %b expected 0", UnfTrap); end
    WimWE = 1; WimIn = 8'h00; tick();
    idle(); Restore = 1; tick(); idle();
    checks++;
    if ({Cwp, Wim, OvfTrap, UnfTrap} !== {3'd1, 8'h00, 1'b0, 1'b0}) begin
      errors++; $display("FAIL restore_ok: got %h expected %h", {Cwp, Wim, OvfTrap, UnfTrap}, {3'd1, 8'h00, 2'b00});
    end
  endtask

  task automatic test_overflow();
    do_reset();
    WimWE = 1; WimIn = 8'h80; tick();
    idle(); Save = 1; tick();
    checks++;
    if ({Cwp, OvfTrap, UnfTrap} !== {3'd0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL ovf_pulse: got %b expected 00010", {Cwp, OvfTrap, UnfTrap});
    end
    tick();
    checks++;
    if (OvfTrap !== 1'b1) begin errors++; $display("FAIL ovf_back_to_back: got %b expected 1", OvfTrap); end
    idle(); tick();
    checks++;
    if (OvfTrap !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", OvfTrap); end
    Save = 1; Restore = 1; tick(); idle();
    checks++;
    if ({Cwp, Wim, OvfTrap, UnfTrap} !== {3'd0, 8'h80, 1'b0, 1'b0}) begin
      errors++; $display("FAIL save_restore_nop: got %h expected %h", {Cwp, Wim, OvfTrap, UnfTrap}, {3'd0, 8'h80, 2'b00});
    end
  endtask

  task automatic test_locals();
    idle(); WimWE = 1; WimIn = 8'h00; tick();
    idle(); WE = 1; RW = 17; Win = 32'h1; tick();
    idle(); Save = 1; tick();
    idle(); WE = 1; RW = 17; Win = 32'h2; tick();
    idle(); Restore = 1; tick();
    idle(); RA = 17; #1;
    checks++;
    if ({Cwp, Aout} !== {3'd0, 32'h1}) begin
      errors++; $display("FAIL locals_private: got cwp=%0d r17=%h expected cwp=0 r17=00000001", Cwp, Aout);
    end
    Save = 1; tick();
    idle(); WimWE = 1; WimIn = 8'hFF; tick();
    idle(); Save = 1; tick(); idle();
    checks++;
    if ({Cwp, OvfTrap} !== {3'd7, 1'b1}) begin
      errors++; $display("FAIL midpulse_setup: got %b expected 1111", {Cwp, OvfTrap});
    end
    Rst_n = 1'b0; #1;
    checks++;
    if ({Cwp, Wim, OvfTrap, UnfTrap} !== {3'd0, 8'h02, 1'b0, 1'b0}) begin
      errors++; $display("FAIL midpulse_reset: got %h expected %h", {Cwp, Wim, OvfTrap, UnfTrap}, {3'd0, 8'h02, 2'b00});
    end
    do_reset();
  endtask

  task automatic test_write_move();
    idle(); WimWE = 1; WimIn = 8'h00; tick();
    idle(); WE = 1; RW = 16; Win = 32'hCAFE; Save = 1; tick();
    idle(); Restore = 1; tick();
    idle(); RA = 16; #1;
    checks++;
    if ({Cwp, Aout} !== {3'd0, 32'hCAFE}) begin
      errors++; $display("FAIL write_pre_move: got cwp=%0d r16=%h expected cwp=0 r16=0000cafe", Cwp, Aout);
    end
  endtask

  task automatic test_bypass();
    logic [DATA_W-1:0] exp;
`ifdef REGWIN_BYPASS_EN
    exp = 32'hDEAD;
`else
    exp = 32'h1111;
`endif
    idle(); WE = 1; RW = 16; Win = 32'h1111; tick();
    idle(); WE = 1; RW = 16; RA = 16; RB = 16; Win = 32'hDEAD; #1;
    checks++;
    if ({Aout, Bout} !== {exp, exp}) begin
      errors++; $display("FAIL bypass_same_cycle: got %h/%h expected %h", Aout, Bout, exp);
    end
    tick();
    idle(); RA = 16; #1;
    checks++;
    if (Aout !== 32'hDEAD) begin errors++; $display("FAIL bypass_after: got %h expected 0000dead", Aout); end
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] ea, eb;
    bit va, vb;
    int op;
    for (int i = 0; i < 400; i++) begin
      RA = 5'($urandom); RB = 5'($urandom); RW = 5'($urandom);
      WE = 1'($urandom); Win = $urandom;
      op = int'($urandom_range(0, 3));
      Save = (op == 1 || op == 3); Restore = (op == 2 || op == 3);
      WimWE = ($urandom_range(0, 5) == 0);
      WimIn = NWIN'($urandom & $urandom & $urandom);
      #1;
      va = m_read(int'(RA), m_cwp, ea);
      vb = m_read(int'(RB), m_cwp, eb);
`ifdef REGWIN_BYPASS_EN
      if (WE) begin va = 0; vb = 0; end
`endif
      if (va) begin
        checks++;
        if (Aout !== ea) begin errors++; $display("FAIL rand_read_a: cycle %0d r%0d got %h expected %h", i, RA, Aout, ea); end
      end
      if (vb) begin
        checks++;
        if (Bout !== eb) begin errors++; $display("FAIL rand_read_b: cycle %0d r%0d got %h expected %h", i, RB, Bout, eb); end
      end
      tick();
      checks++;
      if ({Cwp, Wim, OvfTrap, UnfTrap} !== {CWP_W'(m_cwp), m_wim, m_ovf, m_unf}) begin
        errors++; $display("FAIL rand_state: cycle %0d got %h expected %h", i,
                           {Cwp, Wim, OvfTrap, UnfTrap}, {CWP_W'(m_cwp), m_wim, m_ovf, m_unf});
      end
    end
    idle();
  endtask

  initial begin
    for (int g = 0; g < 8; g++) m_gv[g] = 0;
    for (int w = 0; w < NWIN; w++)
      for (int k = 0; k < 8; k++) begin m_outv[w][k] = 0; m_locv[w][k] = 0; end
    Rst_n = 1'b1;
    m_cwp = 0; m_wim = NWIN'(2); m_ovf = 0; m_unf = 0;
    test_reset();
    test_alias();
    test_globals();
    test_reset_hold();
    test_underflow();
    test_overflow();
    test_locals();
    test_write_move();
    test_bypass();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sparc_window_regfile.md
Name: sparc_window_regfile

Overview:
Parametrised SPARC-style windowed integer register file, the successor of the fixed two-block register window. It holds 8 globals plus NWIN overlapping windows, and provides two combinational read ports and one synchronous write port. It owns the Current Window Pointer (CWP) and the Window Invalid Mask (WIM), executes SAVE/RESTORE, and raises registered overflow/underflow trap pulses toward the trap controller.

Parameters:
DATA_W, 32, register width in bits
NWIN, 8, number of windows; legal range 2..32
CWP_W, 3, CWP width; must equal clog2(NWIN), and be at least 1

Ports:
Clk  input  1  clock; all state updates on the rising edge
Rst_n  input  1  reset; asynchronous, active-low
RA  input  5  read address, port A (architectural r0..r31)
RB  input  5  read address, port B
Aout  output  DATA_W  port A read data
Bout  output  DATA_W  port B read data
RW  input  5  write address
Win  input  DATA_W  write data
WE  input  1  write enable
Save  input  1  SAVE request
Restore  input  1  RESTORE request
WimWE  input  1  WIM write enable
WimIn  input  NWIN  new WIM value
Cwp  output  CWP_W  current window pointer
Wim  output  NWIN  current WIM
OvfTrap  output  1  window-overflow pulse, 1 cycle
UnfTrap  output  1  window-underflow pulse, 1 cycle

Behaviour:
- Architectural map:
  - r0..r7: globals; r0 reads 0 and writes to it are discarded.
  - r8..r15: outs; r16..r23: locals; r24..r31: ins.
- Physical map: window w owns locals[w] and outs[w]. The ins of w alias outs[(w+1) mod NWIN]. Total storage is 8 + 16*NWIN words.
- Reads:
  - Fully combinational from RA/RB and the current Cwp.
  - A read of the same register written in the same cycle returns the old value, unless the optional bypass is enabled.
- Write: on the rising edge when WE=1, using the Cwp value held before that edge.
- SAVE (Save=1, Restore=0):
  - Target window is n = (Cwp-1) mod NWIN, with wrap 0 -> NWIN-1.
  - If WIM[n]=1: Cwp is unchanged and OvfTrap=1 for the next cycle.
  - Otherwise: Cwp <= n.
- RESTORE (Restore=1, Save=0):
  - Target window is n = (Cwp+1) mod NWIN, with wrap NWIN-1 -> 0.
  - If WIM[n]=1: Cwp is unchanged and UnfTrap=1 for the next cycle.
  - Otherwise: Cwp <= n.
- Save and Restore both high: no operation; Cwp is unchanged and neither trap fires.
- WIM update:
  - WimWE=1 loads WimIn at the edge.
  - A SAVE or RESTORE in the same cycle is checked against the old WIM.
- Trap outputs:
  - OvfTrap and UnfTrap are registered.
  - Each is high for exactly one cycle per faulting request, then returns to 0 unless another faulting request occurs.
  - Back-to-back faulting requests give back-to-back pulses.
- Concurrent write and window move: a write in the same cycle as a successful SAVE/RESTORE targets the pre-move window.
- Reset (Rst_n=0, asynchronous):
  - Cwp=0; Wim = one-hot bit 1; OvfTrap=0; UnfTrap=0.
  - Register contents are not reset.
  - Reset asserted mid-operation cancels any pending trap pulse.
  - Writes are ignored while Rst_n=0.
- Latency summary: reads 0 cycles; write visible on the next cycle; Cwp, Wim and trap outputs update 1 cycle after the request.

Optional Feature:
Macro: REGWIN_BYPASS_EN
- Defined: write-to-read forwarding. When WE=1, RW is not 0, and RW resolves to the same physical register as RA (or RB) under the current Cwp, Aout (or Bout) returns Win in the same cycle. Alias hits also forward: an in of window w and an out of window w+1 are the same physical register.
- Undefined: no forwarding; same-cycle reads return the stored value.

Test Plan:
1. Reset, then write r9=0xA5A5A5A5 at Cwp=0, then SAVE -> Cwp=NWIN-1 (7), and reading r25 returns 0xA5A5A5A5 (outs-to-ins alias).
2. Write r0=0xFFFFFFFF and read RA=0 -> Aout=0. Write r3=0x12345678, then SAVE twice -> r3 still reads 0x12345678 (global visible in every window).
3. After reset (Wim=0x02, Cwp=0), RESTORE -> UnfTrap=1 for one cycle and Cwp stays 0. Then load WimIn=0x00 and RESTORE -> Cwp=1 with no trap.
4. Load Wim=0x80, Cwp=0, and SAVE -> OvfTrap pulses and Cwp stays 0. Assert Save and Restore together -> no change and no trap.
5. Write r17=0x1 at Cwp=0, SAVE (Wim=0), write r17=0x2, RESTORE -> r17 reads 0x1 (locals private per window). Also assert Rst_n low mid-pulse -> trap output drops immediately and Cwp=0.
6. With REGWIN_BYPASS_EN defined: WE=1, RW=RA=16, Win=0xDEAD -> Aout=0xDEAD in the same cycle. Without the macro, Aout shows the old value.
